lib_voq_vc: RTL and testbench
=============================

// Module: lib_voq_vc
// PURPOSE
//   Parametrised virtual output queue: M independent FIFO virtual channels (VCs), one per switch output.
//   Each upstream word is written into the single VC named by a onehot valid. The VC head selected
//   by a onehot enable from the output arbiter is read out.
//   Sits between the upstream link and the switch/arbiter at every router input port.
//   Adds configurable data width, per-VC or global backpressure, almost-full thresholds, and sticky error flags.
// PARAMETERS
//   WIDTH      32  data word width in bits
//   M           4  number of VCs (outputs), >=2
//   DEPTH       4  words per VC, power of two, >=2
//   AF_LEVEL    1  o_almost_full[i] asserts when free slots of VC i <= AF_LEVEL (0..DEPTH-1)
//   PER_VC_EN   1  1: o_en per VC; 0: all o_en bits = AND of all per-VC not-full (legacy global mode)
// PORTS
//   clk            in   1         clock, rising edge
//   reset_n        in   1         asynchronous, active-low reset
//   ce             in   1         clock enable; 0 freezes all state (reads and writes ignored)
//   i_data         in   WIDTH     write data from upstream
//   i_data_val     in   [0:M-1]   onehot write strobe; bit i selects VC i; all-zero = idle
//   o_en           out  [0:M-1]   upstream may write VC i next cycle (see BEHAVIOUR)
//   o_almost_full  out  [0:M-1]   per-VC almost-full
//   o_data         out  WIDTH     head word of VC selected by i_en; 0 when i_en is not onehot
//   o_data_val     out  [0:M-1]   VC i is non-empty
//   i_en           in   [0:M-1]   onehot read strobe from arbiter; bit i pops VC i
//   o_err          out  2         sticky: [0] overflow/illegal write, [1] underflow/illegal read
// BEHAVIOUR
//   Reset (async, reset_n=0): all pointers and counts = 0; o_data_val = 0; o_err = 0;
//     o_en = all ones; o_almost_full = 0 (or all ones if AF_LEVEL >= DEPTH-0, i.e. never for legal AF_LEVEL).
//     Stored RAM contents are don't-care.
//   Storage: each VC is a circular buffer with rd/wr pointers of $clog2(DEPTH) bits.
//     Pointers wrap DEPTH-1 -> 0. Count width is $clog2(DEPTH+1).
//   First-word fall-through: o_data is combinational from the selected VC head, with 0-cycle read latency.
//     A write becomes visible at o_data/o_data_val on the next clk edge (1-cycle write-to-valid latency).
//   Write (ce=1, i_data_val[i]=1, exactly one bit set):
//     - Accepted if count[i] < DEPTH, or if count[i] == DEPTH and i_en[i]=1 in the same cycle (full pass-through).
//     - Otherwise dropped and o_err[0] is set.
//   Read (ce=1, i_en[i]=1, exactly one bit set):
//     - Pops VC i if count[i] > 0.
//     - On an empty VC, no change and o_err[1] is set.
//   Simultaneous read and write:
//     - Same VC: count unchanged, both pointers advance.
//     - Different VCs: independent.
//   Non-onehot strobes:
//     - i_data_val with more than one bit set: no write; o_err[0] is set.
//     - i_en with more than one bit set: no pop; o_err[1] is set; o_data = 0.
//   o_en:
//     - PER_VC_EN=1: o_en[i] = (count[i] < DEPTH), registered, i.e. derived from post-edge count.
//     - PER_VC_EN=0: every bit = AND over all VCs of (count < DEPTH).
//   o_almost_full[i] = (DEPTH - count[i]) <= AF_LEVEL, registered with the count.
//   o_err is cleared only by reset.
//   ce=0: no pointer/count/err update. Outputs hold, except o_data, which still follows i_en combinationally.
//   Reset mid-operation: queued words are discarded immediately (o_data_val -> 0 asynchronously).
//     No partial pop or write completes.
// TESTING
//   1 Reset: reset_n=0 with M=4, DEPTH=4 -> o_en=4'b1111, o_data_val=0, o_err=0, o_almost_full=0.
//   2 Per-VC fill: write 0xA0..0xA3 to VC2 -> o_en=4'b1101 after the 4th write, o_almost_full[2]=1 after
//     the 3rd write. A 5th write sets o_err[0]=1, and VC2 still holds 4 words.
//   3 Order and wrap: repeat 3x (write 3 words to VC0, pop 3 words) -> o_data sequence in write order,
//     pointers wrap cleanly, count returns to 0 each round.
//   4 Full pass-through: VC1 full; same cycle i_data_val=4'b0100, i_en=4'b0100, data 0x55 ->
//     no error, count stays 4, 0x55 is read 4 pops later.
//   5 Illegal strobes: i_data_val=4'b0110 -> no write, o_err[0]=1; pop of empty VC3 -> o_err[1]=1;
//     i_en=4'b1100 -> o_data=0.
//   6 Global mode: PER_VC_EN=0, fill VC3 only -> o_en=4'b0000. One pop of VC3 -> o_en=4'b1111 next cycle.
//     Assert reset_n=0 mid-burst -> o_data_val=0 immediately.

Source files
------------

// File: rtl/lib_voq_vc.sv
// Virtual output queue: M first-word-fall-through FIFOs. Read is 0-cycle, write-to-valid is 1 cycle.
// Backpressure: per-VC (or global AND) not-full on o_en. Illegal or lost traffic sets sticky o_err.
module lib_voq_vc #(
   parameter int WIDTH     = 32,
   parameter int M         = 4,
   parameter int DEPTH     = 4,
   parameter int AF_LEVEL  = 1,
   parameter int PER_VC_EN = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             ce,
   input  logic [WIDTH-1:0] i_data,
   input  logic [0:M-1]     i_data_val,
   output logic [0:M-1]     o_en,
   output logic [0:M-1]     o_almost_full,
   output logic [WIDTH-1:0] o_data,
   output logic [0:M-1]     o_data_val,
   input  logic [0:M-1]     i_en,
   output logic [1:0]       o_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [CW-1:0] AFL  = CW'(AF_LEVEL);

   logic [PW-1:0]    rd_ptr [M];
   logic [PW-1:0]    wr_ptr [M];
   logic [CW-1:0]    count  [M];
   logic [WIDTH-1:0] mem    [M][DEPTH];
   logic [1:0]       err;

   logic             wr_oh;
   logic             rd_oh;
   logic             wr_bad;
   logic             rd_bad;
   logic [0:M-1]     pop;
   logic [0:M-1]     push;
   logic [0:M-1]     not_full;

   // A full VC still accepts a write when the same VC is popped this cycle.
   always_comb begin
      wr_oh  = $onehot(i_data_val);
      rd_oh  = $onehot(i_en);
      pop    = '0;
      push   = '0;
      wr_bad = ce && (i_data_val != '0) && !wr_oh;
      rd_bad = ce && (i_en != '0) && !rd_oh;
      for (int i = 0; i < M; i++) begin
         if (ce && rd_oh && i_en[i]) begin
            if (count[i] != '0) pop[i] = 1'b1;
            else                rd_bad = 1'b1;
         end
         if (ce && wr_oh && i_data_val[i]) begin
            if (count[i] != FULL || pop[i]) push[i] = 1'b1;
            else                            wr_bad  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < M; i++) begin
            rd_ptr[i] <= '0;
            wr_ptr[i] <= '0;
            count[i]  <= '0;
         end
         err <= '0;
      end else begin
         for (int i = 0; i < M; i++) begin
            if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
            if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
            if (push[i] && !pop[i])      count[i] <= count[i] + CW'(1);
            else if (pop[i] && !push[i]) count[i] <= count[i] - CW'(1);
         end
         err <= err | {rd_bad, wr_bad};
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < M; i++) begin
         if (push[i]) mem[i][wr_ptr[i]] <= i_data;
      end
   end

   // Status flags are pure functions of the registered counts, so they change only on clock or reset.
   always_comb begin
      o_data = '0;
      for (int i = 0; i < M; i++) begin
         not_full[i]      = (count[i] != FULL);
         o_data_val[i]    = (count[i] != '0);
         o_almost_full[i] = ((FULL - count[i]) <= AFL);
         if (rd_oh && i_en[i]) o_data = mem[i][rd_ptr[i]];
      end
      for (int i = 0; i < M; i++) begin
         o_en[i] = (PER_VC_EN != 0) ? not_full[i] : (&not_full);
      end
   end

   assign o_err = err;

endmodule

// File: tb/tb_lib_voq_vc.sv
// Bench for lib_voq_vc: per-VC and global-mode instances share stimulus and are checked
// every cycle against a queue-based model, plus directed literal checks.
module tb_lib_voq_vc;
   localparam int WIDTH    = 32;
   localparam int M        = 4;
   localparam int DEPTH    = 4;
   localparam int AF_LEVEL = 1;

   logic             clk     = 1'b0;
   logic             reset_n = 1'b1;
   logic             ce      = 1'b1;
   logic [WIDTH-1:0] i_data  = '0;
   logic [0:M-1]     i_data_val = '0;
   logic [0:M-1]     i_en    = '0;

   logic [0:M-1]     o_en, o_almost_full, o_data_val;
   logic [0:M-1]     o_en_g, o_almost_full_g, o_data_val_g;
   logic [WIDTH-1:0] o_data, o_data_g;
   logic [1:0]       o_err, o_err_g;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_on = 1'b0;

   logic [WIDTH-1:0] mq [M][$];
   logic [1:0]       m_err = '0;

   always #5 clk = ~clk;

   lib_voq_vc #(.WIDTH(WIDTH), .M(M), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .PER_VC_EN(1)) dut (
      .clk(clk), .reset_n(reset_n), .ce(ce), .i_data(i_data), .i_data_val(i_data_val),
      .o_en(o_en), .o_almost_full(o_almost_full), .o_data(o_data), .o_data_val(o_data_val),
      .i_en(i_en), .o_err(o_err));

   lib_voq_vc #(.WIDTH(WIDTH), .M(M), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .PER_VC_EN(0)) dut_g (
      .clk(clk), .reset_n(reset_n), .ce(ce), .i_data(i_data), .i_data_val(i_data_val),
      .o_en(o_en_g), .o_almost_full(o_almost_full_g), .o_data(o_data_g), .o_data_val(o_data_val_g),
      .i_en(i_en), .o_err(o_err_g));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [0:M-1] oh(input int i);
      logic [0:M-1] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // Reference model: one queue per VC, rules applied to the pre-edge state.
   initial forever begin
      int r, w;
      bit rv, wv, popping, accept;
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
         for (int i = 0; i < M; i++) mq[i].delete();
         m_err = '0;
      end else if (ce) begin
         rv = $onehot(i_en);
         wv = $onehot(i_data_val);
         r = 0; w = 0; popping = 1'b0; accept = 1'b0;
         for (int i = 0; i < M; i++) begin
            if (i_en[i]) r = i;
            if (i_data_val[i]) w = i;
         end
         if (i_en != '0 && !rv) m_err[1] = 1'b1;
         if (rv) begin
            if (mq[r].size() > 0) popping = 1'b1;
            else                  m_err[1] = 1'b1;
         end
         if (i_data_val != '0 && !wv) m_err[0] = 1'b1;
         if (wv) begin
            if (mq[w].size() < DEPTH || (popping && r == w)) accept = 1'b1;
            else                                             m_err[0] = 1'b1;
         end
         if (popping) void'(mq[r].pop_front());
         if (accept)  mq[w].push_back(i_data);
      end
   end

   task automatic compare();
      logic [0:M-1] e_en, e_af, e_dv;
      bit allnf;
      int r;
      allnf = 1'b1;
      r = 0;
      for (int i = 0; i < M; i++) begin
         e_dv[i] = (mq[i].size() != 0);
         e_af[i] = ((DEPTH - mq[i].size()) <= AF_LEVEL);
         e_en[i] = (mq[i].size() < DEPTH);
         if (!e_en[i]) allnf = 1'b0;
         if (i_en[i]) r = i;
      end
      check("o_en", 64'(o_en), 64'(e_en));
      check("o_en_g", 64'(o_en_g), 64'({M{allnf}}));
      check("o_almost_full", 64'(o_almost_full), 64'(e_af));
      check("o_almost_full_g", 64'(o_almost_full_g), 64'(e_af));
      check("o_data_val", 64'(o_data_val), 64'(e_dv));
      check("o_data_val_g", 64'(o_data_val_g), 64'(e_dv));
      check("o_err", 64'(o_err), 64'(m_err));
      check("o_err_g", 64'(o_err_g), 64'(m_err));
      if ($onehot(i_en)) begin
         if (mq[r].size() > 0) begin
            check("o_data", 64'(o_data), 64'(mq[r][0]));
            check("o_data_g", 64'(o_data_g), 64'(mq[r][0]));
         end
      end else begin
         check("o_data_zero", 64'(o_data), 64'(0));
         check("o_data_zero_g", 64'(o_data_g), 64'(0));
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (chk_on) compare();
   end

   // Called at posedge+2; returns at the following posedge+2 with inputs idle.
   task automatic drive(input logic [0:M-1] dv, input logic [0:M-1] en, input logic [WIDTH-1:0] d);
      i_data_val = dv;
      i_en       = en;
      i_data     = d;
      @(posedge clk);
      #2;
      i_data_val = '0;
      i_en       = '0;
   endtask

   task automatic do_reset();
      i_data_val = '0;
      i_en       = '0;
      ce         = 1'b1;
      reset_n    = 1'b0;
      @(posedge clk);
      #2;
      reset_n = 1'b1;
   endtask

   task automatic pop_expect(input int vc, input logic [WIDTH-1:0] exp, input string name);
      i_en = oh(vc);
      #1;
      check(name, 64'(o_data), 64'(exp));
      drive('0, oh(vc), '0);
   endtask

   function automatic logic [0:M-1] pick(input int p_oh);
      int x;
      x = int'($urandom_range(0, 99));
      if (x < p_oh)      return oh(int'($urandom_range(0, M - 1)));
      else if (x < 90)   return '0;
      else               return M'($urandom);
   endfunction

   initial begin
      // 1: reset values
      #1 reset_n = 1'b0;
      #1;
      check("rst_en", 64'(o_en), 64'(4'b1111));
      check("rst_dv", 64'(o_data_val), 64'(0));
      check("rst_err", 64'(o_err), 64'(0));
      check("rst_af", 64'(o_almost_full), 64'(0));
      chk_on = 1'b1;
      @(posedge clk);
      #2;
      reset_n = 1'b1;

      // 2: per-VC fill of VC2
      for (int k = 0; k < 4; k++) begin
         drive(oh(2), '0, WIDTH'(32'hA0 + k));
         if (k == 1) check("t2_af_2w", 64'(o_almost_full), 64'(0));
         if (k == 2) check("t2_af_3w", 64'(o_almost_full), 64'(4'b0010));
      end
      check("t2_en_full", 64'(o_en), 64'(4'b1101));
      drive(oh(2), '0, 32'hA4);
      check("t2_ovf_err", 64'(o_err), 64'(2'b01));
      check("t2_model_cnt", 64'(mq[2].size()), 64'(4));
      for (int k = 0; k < 4; k++) pop_expect(2, WIDTH'(32'hA0 + k), "t2_order");
      check("t2_drained", 64'(o_data_val), 64'(0));

      // 3: order and pointer wrap on VC0
      do_reset();
      for (int rnd = 0; rnd < 3; rnd++) begin
         for (int k = 0; k < 3; k++) drive(oh(0), '0, WIDTH'(32'hB0 + rnd * 16 + k));
         for (int k = 0; k < 3; k++) pop_expect(0, WIDTH'(32'hB0 + rnd * 16 + k), "t3_order");
         check("t3_empty", 64'(o_data_val), 64'(0));
      end

      // 4: full pass-through on VC1
      do_reset();
      for (int k = 0; k < 4; k++) drive(oh(1), '0, WIDTH'(32'hC0 + k));
      pop_expect(1, 32'hC0, "t4_head");
      drive(oh(1), '0, 32'hC4);
      i_en = 4'b0100;
      #1;
      check("t4_pt_head", 64'(o_data), 64'(32'hC1));
      drive(4'b0100, 4'b0100, 32'h55);
      check("t4_no_err", 64'(o_err), 64'(0));
      check("t4_still_full", 64'(o_en), 64'(4'b1011));
      pop_expect(1, 32'hC2, "t4_p1");
      pop_expect(1, 32'hC3, "t4_p2");
      pop_expect(1, 32'hC4, "t4_p3");
      pop_expect(1, 32'h55, "t4_p4");

      // 5: illegal strobes
      do_reset();
      drive(4'b0110, '0, 32'hDEAD);
      check("t5_multi_wr_err", 64'(o_err), 64'(2'b01));
      check("t5_multi_wr_none", 64'(o_data_val), 64'(0));
      drive('0, oh(3), '0);
      check("t5_underflow", 64'(o_err), 64'(2'b11));
      drive(oh(0), '0, 32'h77);
      i_en = 4'b1100;
      #1;
      check("t5_multi_rd_data", 64'(o_data), 64'(0));
      drive('0, 4'b1100, '0);
      check("t5_multi_rd_nopop", 64'(o_data_val), 64'(4'b1000));

      // 6: global mode and asynchronous reset mid-burst
      do_reset();
      for (int k = 0; k < 4; k++) drive(oh(3), '0, WIDTH'(32'hE0 + k));
      check("t6_glob_full", 64'(o_en_g), 64'(4'b0000));
      check("t6_pervc_full", 64'(o_en), 64'(4'b1110));
      pop_expect(3, 32'hE0, "t6_pop");
      check("t6_glob_free", 64'(o_en_g), 64'(4'b1111));
      drive(oh(0), '0, 32'hF0);
      drive(oh(0), '0, 32'hF1);
      reset_n = 1'b0;
      #1;
      check("t6_async_dv", 64'(o_data_val), 64'(0));
      check("t6_async_dv_g", 64'(o_data_val_g), 64'(0));
      @(posedge clk);
      #2;
      reset_n = 1'b1;

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 499) == 0) do_reset();
         ce = ($urandom_range(0, 9) != 0);
         drive(pick(75), pick(55), $urandom);
      end
      ce = 1'b1;
      drive('0, '0, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
